// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants: major opcodes and immediate formats.
package rv32_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational opcode-to-format decode and 32-bit sign-extended immediate.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr_i,
  output imm_fmt_t    fmt_o,
  output logic [31:0] imm_o
);

  always_comb begin
    fmt_o = FMT_NONE;
    unique case (instr_i[6:0])
      OP_LOAD, OP_JALR, OP_IMM: fmt_o = FMT_I;
      OP_STORE:                 fmt_o = FMT_S;
      OP_BRANCH:                fmt_o = FMT_B;
      OP_LUI, OP_AUIPC:         fmt_o = FMT_U;
      OP_JAL:                   fmt_o = FMT_J;
      OP_REG:                   fmt_o = FMT_R;
      default:                  fmt_o = FMT_NONE;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt_o)
      FMT_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_o = {instr_i[31:12], 12'h000};
      FMT_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode/operand stage: register read with write-back bypass, load-use stall,
// immediate generation and a registered ID/EX slot with valid/ready.
module operand_fetch_stage
  import rv32_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [31:0]        in_instr,
  output logic [RADDR_W-1:0] rs1_addr,
  output logic [RADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]    rs1_val,
  input  logic [XLEN-1:0]    rs2_val,
  input  logic               wb_we,
  input  logic [RADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [31:0]        out_instr,
  output logic [XLEN-1:0]    out_rs1,
  output logic [XLEN-1:0]    out_rs2,
  output logic [XLEN-1:0]    out_imm,
  output logic [RADDR_W-1:0] out_rd,
  output logic               out_is_load
);

  imm_fmt_t     fmt;
  logic [31:0]  imm32;
  logic         uses_rs1, uses_rs2, has_rd, hazard;
  logic [XLEN-1:0] op1, op2;

  logic               valid_q, valid_d;
  logic [XLEN-1:0]    pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
  logic [31:0]        instr_q, instr_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               load_q, load_d;

  imm_gen u_imm_gen (
    .instr_i (in_instr),
    .fmt_o   (fmt),
    .imm_o   (imm32)
  );

  assign rs1_addr = RADDR_W'(in_instr[19:15]);
  assign rs2_addr = RADDR_W'(in_instr[24:20]);

  assign uses_rs1 = (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
  assign uses_rs2 = (fmt == FMT_S) || (fmt == FMT_B) || (fmt == FMT_R);
  assign has_rd   = (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J) || (fmt == FMT_R);

  // x0 reads as zero regardless of bank data or a write-back aimed at it.
  always_comb begin
    op1 = rs1_val;
    op2 = rs2_val;
    if (rs1_addr == '0) op1 = '0;
    else if (wb_we && (wb_addr == rs1_addr)) op1 = wb_data;
    if (rs2_addr == '0) op2 = '0;
    else if (wb_we && (wb_addr == rs2_addr)) op2 = wb_data;
  end

  assign hazard = valid_q && load_q && (rd_q != '0) &&
                  ((uses_rs1 && (rs1_addr == rd_q)) || (uses_rs2 && (rs2_addr == rd_q)));

  assign in_ready = (!valid_q || out_ready) && !hazard && !flush;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    imm_d   = imm_q;
    rd_d    = rd_q;
    load_d  = load_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
      rs1_d   = op1;
      rs2_d   = op2;
      imm_d   = XLEN'($signed(imm32));
      rd_d    = has_rd ? rs1_addr_rd(in_instr) : '0;
      load_d  = (in_instr[6:0] == OP_LOAD);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  function automatic logic [RADDR_W-1:0] rs1_addr_rd(input logic [31:0] instr);
    return RADDR_W'(instr[11:7]);
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      load_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      rd_q    <= rd_d;
      load_q  <= load_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign out_rs1     = rs1_q;
  assign out_rs2     = rs2_q;
  assign out_imm     = imm_q;
  assign out_rd      = rd_q;
  assign out_is_load = load_q;

endmodule
